input_debounce: RTL and testbench

- Input-side counterpart to the blink/LED output path: conditions raw, asynchronous, bouncing board inputs (push buttons, jumpers, `signals` header pins driven externally) into clean, clk-synchronous levels and single-cycle edge events.
- Sits between board pins and processor or debug logic in the BlackiceMx top.
- Per-channel, with optional active-low inversion to match board wiring.

---
 rtl/input_debounce.sv | 90 +++++++++
 tb/tb_input_debounce.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/input_debounce.sv
// Debounces raw board inputs: optional inversion, two-flop synchronizer, then a
// per-channel stability counter that produces clean levels and one-cycle edge pulses.
module input_debounce #(
    parameter int CHANNELS       = 4,
    parameter int CNT_WIDTH      = 18,
    parameter int DEBOUNCE_COUNT = 250000,
    parameter bit ACTIVE_LOW     = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] raw_in,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] pressed,
    output logic [CHANNELS-1:0] released,
    output logic                any_change
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_COUNT - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    logic [CHANNELS-1:0]  in_n;
    logic [CHANNELS-1:0]  sync_p0;
    logic [CHANNELS-1:0]  sync_p1;
    logic [CNT_WIDTH-1:0] cnt     [CHANNELS];
    logic [CNT_WIDTH-1:0] cnt_nxt [CHANNELS];
    state_t               state   [CHANNELS];
    logic [CHANNELS-1:0]  level_nxt;
    logic [CHANNELS-1:0]  pressed_nxt;
    logic [CHANNELS-1:0]  released_nxt;

    assign in_n = ACTIVE_LOW ? ~raw_in : raw_in;

    // Synchronizer stages p0/p1, then debounce state and registered pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0    <= '0;
            sync_p1    <= '0;
            level      <= '0;
            pressed    <= '0;
            released   <= '0;
            any_change <= 1'b0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                cnt[ch] <= '0;
            end
        end else begin
            sync_p0    <= in_n;
            sync_p1    <= sync_p0;
            level      <= level_nxt;
            pressed    <= pressed_nxt;
            released   <= released_nxt;
            any_change <= |(pressed_nxt | released_nxt);
            for (int ch = 0; ch < CHANNELS; ch++) begin
                cnt[ch] <= cnt_nxt[ch];
            end
        end
    end

    // State is implied by whether the synchronized input disagrees with the held level
    always_comb begin
        level_nxt    = level;
        pressed_nxt  = '0;
        released_nxt = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            cnt_nxt[ch] = '0;
            state[ch]   = (sync_p1[ch] != level[ch]) ? PENDING : IDLE;
            case (state[ch])
                IDLE: begin
                    cnt_nxt[ch] = '0;
                end
                PENDING: begin
                    if (cnt[ch] == CNT_LAST) begin
                        level_nxt[ch]    = sync_p1[ch];
                        pressed_nxt[ch]  = sync_p1[ch];
                        released_nxt[ch] = ~sync_p1[ch];
                    end else begin
                        cnt_nxt[ch] = cnt[ch] + 1'b1;
                    end
                end
                default: begin
                    cnt_nxt[ch] = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_input_debounce.sv
// Bench for input_debounce: two instances (active-low/count 4, active-high/count 1)
// compared every cycle against a sliding-window reference model plus directed latency checks.
module tb_input_debounce;

    logic       clk;
    logic       reset;
    logic [3:0] raw_a, raw_b;
    logic [3:0] lvl_a, pr_a, rl_a, lvl_b, pr_b, rl_b;
    logic       any_a, any_b;

    int npass;
    int ntotal;

    input_debounce #(
        .CHANNELS(4), .CNT_WIDTH(18), .DEBOUNCE_COUNT(4), .ACTIVE_LOW(1'b1)
    ) dut_a (
        .clk(clk), .reset(reset), .raw_in(raw_a),
        .level(lvl_a), .pressed(pr_a), .released(rl_a), .any_change(any_a)
    );

    input_debounce #(
        .CHANNELS(4), .CNT_WIDTH(18), .DEBOUNCE_COUNT(1), .ACTIVE_LOW(1'b0)
    ) dut_b (
        .clk(clk), .reset(reset), .raw_in(raw_b),
        .level(lvl_b), .pressed(pr_b), .released(rl_b), .any_change(any_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a level flips when the last DC synchronized samples all
    // differ from it; samples reach the decision two edges after capture.
    int         dcs [2] = '{4, 1};
    bit         als [2] = '{1'b1, 1'b0};
    logic [3:0] m_s1 [2];
    logic [3:0] m_s2 [2];
    logic [3:0] m_lvl[2];
    logic [3:0] m_pr [2];
    logic [3:0] m_rl [2];
    logic       m_any[2];
    logic       m_hist[2][4][8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntotal++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_s1[k] = '0; m_s2[k] = '0; m_lvl[k] = '0;
            m_pr[k] = '0; m_rl[k] = '0; m_any[k] = 1'b0;
            for (int ch = 0; ch < 4; ch++)
                for (int i = 0; i < 8; i++) m_hist[k][ch][i] = 1'b0;
        end
    endtask

    task automatic model_edge(input int k, input logic [3:0] raw);
        logic [3:0] inn;
        bit         all;
        inn = als[k] ? ~raw : raw;
        m_pr[k] = '0;
        m_rl[k] = '0;
        for (int ch = 0; ch < 4; ch++) begin
            for (int i = 7; i > 0; i--) m_hist[k][ch][i] = m_hist[k][ch][i-1];
            m_hist[k][ch][0] = m_s2[k][ch];
            all = 1'b1;
            for (int i = 0; i < dcs[k]; i++)
                if (m_hist[k][ch][i] == m_lvl[k][ch]) all = 1'b0;
            if (all) begin
                if (m_lvl[k][ch]) m_rl[k][ch] = 1'b1;
                else              m_pr[k][ch] = 1'b1;
                m_lvl[k][ch] = ~m_lvl[k][ch];
            end
        end
        m_any[k] = |(m_pr[k] | m_rl[k]);
        m_s2[k]  = m_s1[k];
        m_s1[k]  = inn;
    endtask

    task automatic check_outputs();
        chk("a_level",    lvl_a, m_lvl[0]);
        chk("a_pressed",  pr_a,  m_pr[0]);
        chk("a_released", rl_a,  m_rl[0]);
        chk("a_any",      any_a, m_any[0]);
        chk("b_level",    lvl_b, m_lvl[1]);
        chk("b_pressed",  pr_b,  m_pr[1]);
        chk("b_released", rl_b,  m_rl[1]);
        chk("b_any",      any_b, m_any[1]);
    endtask

    task automatic tick();
        if (!reset) begin
            model_edge(0, raw_a);
            model_edge(1, raw_b);
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    // Asserted mid-cycle so the asynchronous clear is visible before any edge
    task automatic apply_reset(input int hold);
        reset = 1'b1;
        #1;
        model_clear();
        chk("rst_level",  {lvl_a, lvl_b}, 8'h00);
        chk("rst_pulses", {pr_a, rl_a, pr_b, rl_b}, 16'h0000);
        chk("rst_any",    {any_a, any_b}, 2'b00);
        for (int i = 0; i < hold; i++) tick();
        #1 reset = 1'b0;
    endtask

    initial begin
        int n, cnt_p, cnt_r, cnt_any;
        npass  = 0;
        ntotal = 0;
        raw_a  = 4'hF;
        raw_b  = 4'h0;
        reset  = 1'b1;
        model_clear();
        #1;

        // Test 1: inputs idle (high, active-low) through reset and after
        apply_reset(3);
        for (int i = 0; i < 12; i++) tick();
        chk("t1_level_idle", lvl_a, 4'h0);

        // Test 2: channel 0 press latency
        raw_a[0] = 1'b0;
        n = 0;
        while (lvl_a[0] !== 1'b1 && n < 20) begin tick(); n++; end
        chk("t2_latency", n, 6);
        chk("t2_pressed", pr_a, 4'b0001);
        chk("t2_any", any_a, 1'b1);
        tick();
        chk("t2_pulse_once", pr_a, 4'b0000);

        // Test 3: glitch during pending on channel 1
        cnt_p = 0;
        raw_a[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin tick(); if (pr_a[1]) cnt_p++; end
        raw_a[1] = 1'b1;
        tick(); if (pr_a[1]) cnt_p++;
        raw_a[1] = 1'b0;
        n = 0;
        while (lvl_a[1] !== 1'b1 && n < 20) begin tick(); n++; if (pr_a[1]) cnt_p++; end
        chk("t3_relatency", n, 6);
        for (int i = 0; i < 6; i++) begin tick(); if (pr_a[1]) cnt_p++; end
        chk("t3_one_pulse", cnt_p, 1);

        // Test 4: channels 2 and 3 together
        cnt_p = 0; cnt_r = 0; cnt_any = 0;
        raw_a[3:2] = 2'b00;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (pr_a == 4'b1100) cnt_p++;
            if (any_a) cnt_any++;
        end
        raw_a[3:2] = 2'b11;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (rl_a == 4'b1100) cnt_r++;
            if (any_a) cnt_any++;
        end
        chk("t4_pressed_pair", cnt_p, 1);
        chk("t4_released_pair", cnt_r, 1);
        chk("t4_any_count", cnt_any, 2);

        // Test 5: reset mid-count discards progress; held input accepted after release
        raw_a = 4'hF;
        apply_reset(2);
        for (int i = 0; i < 3; i++) tick();
        raw_a[0] = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        apply_reset(2);
        chk("t5_level_after_rst", lvl_a, 4'h0);
        n = 0;
        while (pr_a[0] !== 1'b1 && n < 20) begin tick(); n++; end
        chk("t5_accept", n, 6);
        chk("t5_level", lvl_a[0], 1'b1);

        // Test 6: active-high, count 1 instance
        raw_b[0] = 1'b1;
        n = 0;
        while (lvl_b[0] !== 1'b1 && n < 20) begin tick(); n++; end
        chk("t6_latency", n, 3);
        chk("t6_pressed", pr_b, 4'b0001);
        cnt_p = 0; cnt_r = 0;
        for (int i = 0; i < 16; i++) begin
            if (i < 12 && i % 3 == 0) raw_b[0] = ~raw_b[0];
            tick();
            if (pr_b[0]) cnt_p++;
            if (rl_b[0]) cnt_r++;
        end
        chk("t6_toggle_pressed", cnt_p, 2);
        chk("t6_toggle_released", cnt_r, 2);

        // Randomized bouncing on both instances with occasional resets
        for (int i = 0; i < 2000; i++) begin
            for (int ch = 0; ch < 4; ch++) begin
                if ($urandom_range(0, 5) == 0) raw_a[ch] = ~raw_a[ch];
                if ($urandom_range(0, 2) == 0) raw_b[ch] = ~raw_b[ch];
            end
            if ($urandom_range(0, 399) == 0) apply_reset($urandom_range(0, 3));
            tick();
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
